// File: rtl/wasm_typed_stack.sv
// wasm_typed_stack: type-tagged WebAssembly operand stack with an in-block
// SELECT sequencer. Each entry holds a 2-bit valtype tag (0 i32, 1 i64,
// 2 f32, 3 f64) and a WIDTH-bit value (WIDTH >= 32).
//
// Optional feature macro: TYPED_SELECT_EN
//   defined   -> op 5 (SELECT_T) is SELECT plus a check that the selected
//                operands carry the immediate type given on op_type.
//   undefined -> ops 5..7 behave as NOP.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   op_valid   request valid; accepted when op_valid && op_ready
//   op_ready   block can accept a request this cycle
//   op         0 NOP, 1 PUSH, 2 POP, 3 DROP, 4 SELECT, 5 SELECT_T
//   op_type    push tag / SELECT_T immediate type
//   push_data  value for PUSH
//   top_data   value at top of stack (0 when empty)
//   top_type   tag at top of stack (0 when empty)
//   depth      entries held
//   empty      depth == 0
//   full       depth == DEPTH
//   done       one-cycle pulse when an op completes without trap
//   trap       sticky trap code (`NONE, `STACK_OVERFLOW, `STACK_UNDERFLOW,
//              `TYPES_MISMATCH)

`ifndef NONE
`define NONE 3'd0
`endif
`ifndef STACK_OVERFLOW
`define STACK_OVERFLOW 3'd1
`endif
`ifndef STACK_UNDERFLOW
`define STACK_UNDERFLOW 3'd2
`endif
`ifndef TYPES_MISMATCH
`define TYPES_MISMATCH 3'd3
`endif

module wasm_typed_stack #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [1:0]       op_type,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [1:0]       top_type,
  output logic [PTR_W-1:0] depth,
  output logic             empty,
  output logic             full,
  output logic             done,
  output logic [2:0]       trap
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EW    = WIDTH + 2;

  localparam logic [2:0] OP_PUSH     = 3'd1;
  localparam logic [2:0] OP_POP      = 3'd2;
  localparam logic [2:0] OP_DROP     = 3'd3;
  localparam logic [2:0] OP_SELECT   = 3'd4;
  localparam logic [2:0] OP_SELECT_T = 3'd5;
  localparam logic [1:0] T_I32       = 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_SEL_C, S_SEL_B, S_SEL_A} state_e;

  logic [EW-1:0]    mem_q [DEPTH];
  state_e           state_q;
  logic [PTR_W-1:0] depth_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] sp0_q;
  logic [1:0]       cond_ty_q;
  logic [31:0]      cond_lo_q;
  logic [EW-1:0]    val1_q;
  logic [EW-1:0]    val2_q;
  logic             done_q;
  logic [2:0]       trap_q;
`ifdef TYPED_SELECT_EN
  logic             typed_q;
  logic [1:0]       sel_ty_q;
`endif

  logic             accept;
  logic             is_sel;
  logic             sel_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [EW-1:0]    rd_ent;
  logic [EW-1:0]    sel_pick;
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;
  logic [EW-1:0]    mem_wdata;

  assign op_ready = (state_q == S_IDLE) && (trap_q == `NONE);
  assign accept   = op_valid && op_ready;
  assign empty    = (depth_q == '0);
  assign full     = (depth_q == PTR_W'(DEPTH));
  assign depth    = depth_q;
  assign done     = done_q;
  assign trap     = trap_q;

`ifdef TYPED_SELECT_EN
  assign is_sel = (op == OP_SELECT) || (op == OP_SELECT_T);
  assign sel_ok = (val1_q[EW-1:WIDTH] == val2_q[EW-1:WIDTH]) &&
                  (!typed_q || (val1_q[EW-1:WIDTH] == sel_ty_q));
`else
  assign is_sel = (op == OP_SELECT);
  assign sel_ok = (val1_q[EW-1:WIDTH] == val2_q[EW-1:WIDTH]);
`endif

  // The single read port serves the top-of-stack view while idle and the
  // SELECT operand fetches otherwise, hence top_* are undefined mid-SELECT.
  always_comb begin
    rd_idx = (state_q == S_IDLE) ? IDX_W'(depth_q - PTR_W'(1)) : IDX_W'(ptr_q);
    rd_ent = mem_q[rd_idx];
  end

  assign top_data = empty ? '0 : rd_ent[WIDTH-1:0];
  assign top_type = empty ? '0 : rd_ent[EW-1:WIDTH];

  assign sel_pick = (cond_lo_q != '0) ? val1_q : val2_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = '0;
    mem_wdata = '0;
    if (accept && (op == OP_PUSH) && !full) begin
      mem_we    = 1'b1;
      mem_widx  = IDX_W'(depth_q);
      mem_wdata = {op_type, push_data};
    end else if ((state_q == S_SEL_A) && sel_ok) begin
      // ptr_q has been walked down to sp0-3 by this point
      mem_we    = 1'b1;
      mem_widx  = IDX_W'(ptr_q);
      mem_wdata = sel_pick;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_widx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      depth_q   <= '0;
      ptr_q     <= '0;
      sp0_q     <= '0;
      cond_ty_q <= '0;
      cond_lo_q <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      done_q    <= 1'b0;
      trap_q    <= `NONE;
`ifdef TYPED_SELECT_EN
      typed_q   <= 1'b0;
      sel_ty_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_sel) begin
              if (depth_q < PTR_W'(3)) begin
                trap_q <= `STACK_UNDERFLOW;
              end else begin
                cond_ty_q <= rd_ent[EW-1:WIDTH];
                cond_lo_q <= rd_ent[31:0];
                sp0_q     <= depth_q;
                ptr_q     <= depth_q - PTR_W'(2);
                state_q   <= S_SEL_C;
`ifdef TYPED_SELECT_EN
                typed_q   <= (op == OP_SELECT_T);
                sel_ty_q  <= op_type;
`endif
              end
            end else begin
              case (op)
                OP_PUSH: begin
                  if (full) begin
                    trap_q <= `STACK_OVERFLOW;
                  end else begin
                    depth_q <= depth_q + PTR_W'(1);
                    done_q  <= 1'b1;
                  end
                end
                OP_POP, OP_DROP: begin
                  if (empty) begin
                    trap_q <= `STACK_UNDERFLOW;
                  end else begin
                    depth_q <= depth_q - PTR_W'(1);
                    done_q  <= 1'b1;
                  end
                end
                default: done_q <= 1'b1;
              endcase
            end
          end
        end
        S_SEL_C: begin
          if (cond_ty_q != T_I32) begin
            trap_q  <= `TYPES_MISMATCH;
            state_q <= S_IDLE;
          end else begin
            val2_q  <= rd_ent;
            ptr_q   <= ptr_q - PTR_W'(1);
            state_q <= S_SEL_B;
          end
        end
        S_SEL_B: begin
          val1_q  <= rd_ent;
          state_q <= S_SEL_A;
        end
        S_SEL_A: begin
          state_q <= S_IDLE;
          if (!sel_ok) begin
            trap_q <= `TYPES_MISMATCH;
          end else begin
            depth_q <= sp0_q - PTR_W'(2);
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_typed_stack.sv
module tb_wasm_typed_stack;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned PTR_W = $clog2(DEPTH + 1);

  localparam logic [2:0] TR_NONE = 3'd0;
  localparam logic [2:0] TR_OVF  = 3'd1;
  localparam logic [2:0] TR_UNF  = 3'd2;
  localparam logic [2:0] TR_MISM = 3'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [1:0]       op_type;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] top_data;
  logic [1:0]       top_type;
  logic [PTR_W-1:0] depth;
  logic             empty;
  logic             full;
  logic             done;
  logic [2:0]       trap;

  always #5 clk = ~clk;

  wasm_typed_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .op_type(op_type), .push_data(push_data),
    .top_data(top_data), .top_type(top_type), .depth(depth),
    .empty(empty), .full(full), .done(done), .trap(trap)
  );

  typedef struct {
    logic [1:0]       t;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_trapped;
  int   tests = 0;
  int   fails = 0;

  // Reference model: the stack as a queue, top at the back.
  function automatic void model_op(input logic [2:0] o, input logic [1:0] t,
                                   input logic [WIDTH-1:0] d,
                                   output logic [2:0] etrap, output int elat);
    ent_t c, v1, v2, r;
    bit   is_sel, typed;
    etrap  = TR_NONE;
    elat   = 1;
    is_sel = (o == 3'd4);
    typed  = 1'b0;
`ifdef TYPED_SELECT_EN
    if (o == 3'd5) begin is_sel = 1'b1; typed = 1'b1; end
`endif
    if (is_sel) begin
      elat = 4;
      if (mq.size() < 3) etrap = TR_UNF;
      else begin
        c  = mq[$];
        v2 = mq[$-1];
        v1 = mq[$-2];
        if (c.t != 2'd0) etrap = TR_MISM;
        else if (v1.t != v2.t) etrap = TR_MISM;
        else if (typed && v1.t != t) etrap = TR_MISM;
        else begin
          r = (c.d[31:0] != 32'd0) ? v1 : v2;
          void'(mq.pop_back()); void'(mq.pop_back()); void'(mq.pop_back());
          mq.push_back(r);
        end
      end
    end else if (o == 3'd1) begin
      if (mq.size() == DEPTH) etrap = TR_OVF;
      else mq.push_back('{t, d});
    end else if (o == 3'd2 || o == 3'd3) begin
      if (mq.size() == 0) etrap = TR_UNF;
      else void'(mq.pop_back());
    end
    if (etrap != TR_NONE) m_trapped = 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    op_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mq.delete();
    m_trapped = 1'b0;
  endtask

  // Issues one request, then checks completion and the resulting visible state.
  task automatic apply_op(input string name, input logic [2:0] o,
                          input logic [1:0] t, input logic [WIDTH-1:0] d);
    logic [2:0]       etrap;
    logic [WIDTH-1:0] ed;
    logic [1:0]       et;
    int               elat, dcount, dfirst, w;
    w = 0;
    while (!op_ready && w < 10) begin @(negedge clk); w++; end
    if (!op_ready) begin
      tests++; fails++;
      $display("FAIL %s ready_timeout: op_ready=%b required 1", name, op_ready);
      return;
    end
    model_op(o, t, d, etrap, elat);
    op_valid = 1'b1; op = o; op_type = t; push_data = d;
    @(posedge clk);
    #1 op_valid = 1'b0; op = 3'd0;
    dcount = 0; dfirst = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin dcount++; if (dfirst == 0) dfirst = k; end
    end
    tests++;
    if (etrap == TR_NONE) begin
      if (dcount !== 1 || dfirst !== elat) begin
        fails++;
        $display("FAIL %s done: pulses=%0d at edge %0d, required 1 at edge %0d", name, dcount, dfirst, elat);
      end
    end else if (dcount !== 0) begin
      fails++;
      $display("FAIL %s done_on_trap: pulses=%0d required 0", name, dcount);
    end
    tests++;
    if (trap !== etrap) begin
      fails++; $display("FAIL %s trap: got %0d required %0d", name, trap, etrap);
    end
    tests++;
    if (depth !== PTR_W'(mq.size())) begin
      fails++; $display("FAIL %s depth: got %0d required %0d", name, depth, mq.size());
    end
    ed = '0; et = '0;
    if (mq.size() > 0) begin ed = mq[$].d; et = mq[$].t; end
    tests++;
    if (top_data !== ed) begin
      fails++; $display("FAIL %s top_data: got %h required %h", name, top_data, ed);
    end
    tests++;
    if (top_type !== et) begin
      fails++; $display("FAIL %s top_type: got %0d required %0d", name, top_type, et);
    end
    tests++;
    if ({empty, full} !== {mq.size() == 0, mq.size() == DEPTH}) begin
      fails++; $display("FAIL %s empty_full: got %b%b required %b%b", name, empty, full,
                        mq.size() == 0, mq.size() == DEPTH);
    end
    tests++;
    if (op_ready !== !m_trapped) begin
      fails++; $display("FAIL %s op_ready: got %b required %b", name, op_ready, !m_trapped);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({depth, trap, done, op_ready, empty, full} !== {PTR_W'(0), TR_NONE, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_ctrl: depth=%0d trap=%0d done=%b ready=%b empty=%b full=%b required 0 0 0 1 1 0",
               depth, trap, done, op_ready, empty, full);
    end
    tests++;
    if (top_data !== '0 || top_type !== 2'd0) begin
      fails++; $display("FAIL reset_top: data=%h type=%0d required 0 0", top_data, top_type);
    end
  endtask

  task automatic test_select_basic();
    do_reset();
    apply_op("sel1_push5", 3'd1, 2'd0, 64'd5);
    apply_op("sel1_push7", 3'd1, 2'd0, 64'd7);
    apply_op("sel1_push1", 3'd1, 2'd0, 64'd1);
    apply_op("sel1_select", 3'd4, 2'd0, '0);
    apply_op("sel1_drop", 3'd3, 2'd0, '0);
    apply_op("sel2_pushAA", 3'd1, 2'd1, 64'hAA);
    apply_op("sel2_pushBB", 3'd1, 2'd1, 64'hBB);
    apply_op("sel2_push0", 3'd1, 2'd0, 64'd0);
    apply_op("sel2_select", 3'd4, 2'd0, '0);
    // nonzero only above bit 31: cond still counts as false
    apply_op("sel3_pushA", 3'd1, 2'd2, 64'h11);
    apply_op("sel3_pushB", 3'd1, 2'd2, 64'h22);
    apply_op("sel3_cond", 3'd1, 2'd0, 64'hFFFF_0000_0000_0000);
    apply_op("sel3_select", 3'd4, 2'd0, '0);
  endtask

  task automatic test_type_mismatch();
    int bad;
    do_reset();
    apply_op("mm_push5", 3'd1, 2'd0, 64'd5);
    apply_op("mm_push7", 3'd1, 2'd1, 64'd7);
    apply_op("mm_push1", 3'd1, 2'd0, 64'd1);
    apply_op("mm_select", 3'd4, 2'd0, '0);
    bad = 0;
    op_valid = 1'b1; op = 3'd1; op_type = 2'd0; push_data = 64'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (op_ready !== 1'b0 || depth !== PTR_W'(3) || trap !== TR_MISM) bad++;
    end
    op_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL mm_sticky: %0d cycles deviated from ready=0 depth=3 trap=3, required 0", bad);
    end
    do_reset();
    tests++;
    if (trap !== TR_NONE || depth !== PTR_W'(0) || op_ready !== 1'b1) begin
      fails++; $display("FAIL mm_reset: trap=%0d depth=%0d ready=%b required 0 0 1", trap, depth, op_ready);
    end
  endtask

  task automatic test_cond_mismatch();
    do_reset();
    apply_op("cm_push1", 3'd1, 2'd2, 64'd1);
    apply_op("cm_push2", 3'd1, 2'd2, 64'd2);
    apply_op("cm_push3", 3'd1, 2'd3, 64'd3);
    apply_op("cm_select", 3'd4, 2'd0, '0);
  endtask

  task automatic test_bounds();
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++)
      apply_op("ovf_push", 3'd1, 2'($urandom_range(0, 3)), {$urandom, $urandom});
    do_reset();
    apply_op("unf_pop", 3'd2, 2'd0, '0);
    do_reset();
    apply_op("unf_drop", 3'd3, 2'd0, '0);
    do_reset();
    apply_op("sunf_push1", 3'd1, 2'd0, 64'd1);
    apply_op("sunf_push2", 3'd1, 2'd0, 64'd2);
    apply_op("sunf_select", 3'd4, 2'd0, '0);
  endtask

  task automatic test_select_t();
    do_reset();
    apply_op("st_pushA", 3'd1, 2'd0, 64'h123);
    apply_op("st_pushB", 3'd1, 2'd0, 64'h456);
    apply_op("st_cond", 3'd1, 2'd0, 64'd1);
    apply_op("st_select_t", 3'd5, 2'd1, '0);
    if (!m_trapped) begin
      apply_op("st_op6", 3'd6, 2'd0, '0);
      apply_op("st_op7", 3'd7, 2'd0, '0);
      apply_op("st_nop", 3'd0, 2'd0, '0);
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] v;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      v = {$urandom, $urandom};
      op_valid = 1'b1; op = 3'd1; op_type = 2'd1; push_data = v;
      mq.push_back('{2'd1, v});
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b1 || depth !== PTR_W'(mq.size()) || top_data !== v) bad++;
    end
    for (int i = 0; i < 4; i++) begin
      op_valid = 1'b1; op = 3'd2;
      void'(mq.pop_back());
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b1 || depth !== PTR_W'(mq.size())) bad++;
    end
    op_valid = 1'b0;
    tests++;
    if (bad != 0 || empty !== 1'b1) begin
      fails++; $display("FAIL b2b: %0d bad cycles, empty=%b, required 0 and 1", bad, empty);
    end
  endtask

  task automatic test_reset_mid_select();
    int dcount;
    do_reset();
    apply_op("rm_push1", 3'd1, 2'd0, 64'd1);
    apply_op("rm_push2", 3'd1, 2'd0, 64'd2);
    apply_op("rm_push3", 3'd1, 2'd0, 64'd3);
    op_valid = 1'b1; op = 3'd4;
    @(posedge clk);
    #1 op_valid = 1'b0; op = 3'd0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    tests++;
    if (op_ready !== 1'b1 || depth !== PTR_W'(0) || done !== 1'b0 || trap !== TR_NONE) begin
      fails++; $display("FAIL rm_abort: ready=%b depth=%0d done=%b trap=%0d required 1 0 0 0",
                        op_ready, depth, done, trap);
    end
    @(negedge clk);
    reset = 1'b1;
    mq.delete();
    m_trapped = 1'b0;
    dcount = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (done === 1'b1) dcount++; end
    tests++;
    if (dcount != 0 || depth !== PTR_W'(0)) begin
      fails++; $display("FAIL rm_after: done pulses=%0d depth=%0d required 0 0", dcount, depth);
    end
  endtask

  task automatic test_random();
    logic [2:0]       o;
    logic [1:0]       t;
    logic [WIDTH-1:0] d;
    int               r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (m_trapped) do_reset();
      r = $urandom_range(0, 99);
      if (r < 45) o = 3'd1;
      else if (r < 55) o = 3'd2;
      else if (r < 65) o = 3'd3;
      else if (r < 90) o = 3'd4;
      else o = 3'($urandom_range(5, 7));
      t = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(0, 3));
      r = $urandom_range(0, 3);
      if (r == 0) d = '0;
      else if (r == 1) d = {$urandom, 32'd0};
      else d = {$urandom, $urandom};
      apply_op("rand", o, t, d);
    end
  endtask

  initial begin
    reset = 1'b0;
    op_valid = 1'b0; op = '0; op_type = '0; push_data = '0;
    m_trapped = 1'b0;
    test_reset();
    test_select_basic();
    test_type_mismatch();
    test_cond_mismatch();
    test_bounds();
    test_select_t();
    test_back_to_back();
    test_reset_mid_select();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/wasm_typed_stack.md
Name: wasm_typed_stack

Overview:
- Parametrised, type-tagged WebAssembly operand stack with an in-block `select` sequencer.
- Holds values with a 2-bit valtype tag and executes PUSH/POP/DROP/SELECT requests from the CPU decode stage.
- Raises sticky traps (overflow, underflow, type mismatch) on the same 3-bit trap encoding the CPU exports.
- Storage is single-read-port, so SELECT is a multi-cycle sequence.

Parameters:
- WIDTH, 64, value width in bits.
- DEPTH, 16, stack entries (>=4).
- PTR_W, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- op_valid  input  1  request valid
- op_ready  output  1  block can accept a request this cycle
- op  input  3  0 NOP, 1 PUSH, 2 POP, 3 DROP, 4 SELECT, 5 SELECT_T (macro only)
- op_type  input  2  push tag / SELECT_T immediate type: 0 i32, 1 i64, 2 f32, 3 f64
- push_data  input  WIDTH  value for PUSH
- top_data  output  WIDTH  value at top of stack (0 when empty)
- top_type  output  2  tag at top of stack (0 when empty)
- depth  output  PTR_W  entries held
- empty  output  1  depth==0
- full  output  1  depth==DEPTH
- done  output  1  one-cycle pulse when an op completes without trap
- trap  output  3  `NONE, `STACK_OVERFLOW, `STACK_UNDERFLOW, `TYPES_MISMATCH (cpu.vh macros)

Behaviour:
- Reset (reset low, asynchronous):
  - depth=0, trap=`NONE, done=0, op_ready=1, FSM in IDLE, top_data/top_type=0.
  - Array contents are don't-care.
  - Reset mid-SELECT aborts the sequence immediately.
- Handshake: request accepted on a rising edge with op_valid && op_ready. op/data are sampled only at acceptance.
- PUSH:
  - If full: trap=`STACK_OVERFLOW, stack unchanged.
  - Otherwise write {op_type, push_data} at index depth and increment depth.
  - 1 cycle; done pulses the following cycle.
- POP/DROP:
  - If empty: trap=`STACK_UNDERFLOW.
  - Otherwise decrement depth. Both are identical here; POP exists for the decode stage to consume top_data in the acceptance cycle.
- NOP: done pulses; no other effect.
- SELECT FSM: IDLE -> SEL_C -> SEL_B -> SEL_A -> IDLE.
  - Acceptance cycle (IDLE):
    - If depth<3: trap=`STACK_UNDERFLOW, no state change.
    - Else latch cond={tag,data} of top, save depth as sp0, pointer=depth-2; go to SEL_C. op_ready drops to 0.
  - SEL_C:
    - cond tag != i32 -> trap=`TYPES_MISMATCH.
    - Else read val2 at pointer, pointer-1, go to SEL_B.
  - SEL_B: read val1 at pointer, go to SEL_A.
  - SEL_A:
    - val1 tag != val2 tag -> `TYPES_MISMATCH.
    - Else write (cond[31:0]!=0 ? val1 : val2), with its tag, at index sp0-3. Set depth=sp0-2. Pulse done, return to IDLE.
  - Only the low 32 bits of cond are tested.
  - Acceptance to done pulse: 4 clock edges. op_ready is low for 3 cycles.
- Trap rule:
  - On any trap, depth and array are restored/left at their pre-op values (no write occurs before SEL_A passes its check). done is not pulsed.
  - trap is sticky. While trap != `NONE, op_ready=0 until reset.
- Only one trap code is latched: the first detected.
- top_data/top_type are combinational from the entry at depth-1.
- During SELECT they are undefined until done.

Optional Feature:
- Macro: TYPED_SELECT_EN.
- Defined: op=5 (SELECT_T) is legal. It behaves as SELECT plus a check in SEL_A that val1 tag == op_type, else `TYPES_MISMATCH.
- Undefined: op=5 and op=6/7 are treated as NOP.

Test Plan:
- Push i32 5, i32 7, i32 1, SELECT -> done 4 edges after acceptance; depth=1, top_data=5, top_type=0, trap=`NONE.
- Push i64 0xAA, i64 0xBB, i32 0, SELECT -> top_data=0xBB, top_type=1, depth=1.
- Push i32 5, i64 7, i32 1, SELECT -> trap=`TYPES_MISMATCH, depth=3, op_ready stays 0 until reset; then reset low -> trap=`NONE, depth=0.
- Push f32 1, f32 2, f64 3, SELECT -> `TYPES_MISMATCH from SEL_C, depth=3.
- DEPTH=16: 16 PUSHes -> full=1; 17th PUSH -> `STACK_OVERFLOW, depth=16. Separately, POP on empty -> `STACK_UNDERFLOW; SELECT with depth=2 -> `STACK_UNDERFLOW.
- With TYPED_SELECT_EN: i32 a, i32 b, cond 1, SELECT_T op_type=i64 -> `TYPES_MISMATCH. Without the macro, the same op is a NOP: done pulses, depth stays 3.
